// File: rtl/routine_pkg.sv
// Shared constants and FSM state encoding for the routine scheduler and its bus mux.
package routine_pkg;

    localparam int WORD_WIDTH             = 16;
    localparam int IDX_WIDTH              = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LAUNCH,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/routine_bus_mux.sv
// Zero-latency N-way selector that hands the shared register bank port to one routine slot.
module routine_bus_mux #(
    parameter int WORD_WIDTH = routine_pkg::WORD_WIDTH,
    parameter int N_ROUTINES = 4,
    parameter int IDX_WIDTH  = routine_pkg::IDX_WIDTH
) (
    input  logic                             grant,
    input  logic [IDX_WIDTH-1:0]             sel,
    input  logic [N_ROUTINES*WORD_WIDTH-1:0] routine_address,
    input  logic [N_ROUTINES-1:0]            routine_wr_en,
    input  logic [N_ROUTINES*WORD_WIDTH-1:0] routine_data_out,
    output logic [WORD_WIDTH-1:0]            mem_address,
    output logic                             mem_wr_en,
    output logic [WORD_WIDTH-1:0]            mem_data_out
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        mem_address  = '0;
        mem_wr_en    = 1'b0;
        mem_data_out = '0;
        if (grant) begin
            for (int i = 0; i < N_ROUTINES; i++) begin
                if (sel == IDX_WIDTH'(i)) begin
                    mem_address  = routine_address[i*WORD_WIDTH +: WORD_WIDTH];
                    mem_wr_en    = routine_wr_en[i];
                    mem_data_out = routine_data_out[i*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/routine_scheduler.sv
// Runs enabled node routines one at a time and arbitrates the shared bank port.
// Optional per-routine WAIT timeout is built when ROUTINE_TIMEOUT_EN is defined.
module routine_scheduler #(
    parameter int WORD_WIDTH     = routine_pkg::WORD_WIDTH,
    parameter int N_ROUTINES     = 4,
    parameter int TIMEOUT_CYCLES = routine_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                              clock,
    input  logic                              nrst,
    input  logic                              start,
    input  logic [N_ROUTINES-1:0]             enable,
    input  logic [N_ROUTINES-1:0]             routine_done,
    input  logic [N_ROUTINES*WORD_WIDTH-1:0]  routine_address,
    input  logic [N_ROUTINES-1:0]             routine_wr_en,
    input  logic [N_ROUTINES*WORD_WIDTH-1:0]  routine_data_out,
    output logic [N_ROUTINES-1:0]             routine_start,
    output logic [N_ROUTINES-1:0]             routine_nrst,
    output logic [WORD_WIDTH-1:0]             mem_address,
    output logic                              mem_wr_en,
    output logic [WORD_WIDTH-1:0]             mem_data_out,
    output logic                              busy,
    output logic                              done,
    output logic [routine_pkg::IDX_WIDTH-1:0] current,
    output logic [N_ROUTINES-1:0]             timeout_err
);
    import routine_pkg::*;

    state_t                state, state_next;
    logic [N_ROUTINES-1:0] mask;
    logic [IDX_WIDTH-1:0]  first_idx, next_idx;
    logic                  first_found, next_found;
    logic                  done_sel, timeout_hit, start_accept, grant;

    assign start_accept = start && (state == ST_IDLE || state == ST_DONE);

    // Lowest set bit of enable (start scan) and lowest mask bit above current (advance).
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        done_sel    = 1'b0;
        for (int i = N_ROUTINES - 1; i >= 0; i--) begin
            if (enable[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_WIDTH'(i);
            end
            if (mask[i] && IDX_WIDTH'(i) > current) begin
                next_found = 1'b1;
                next_idx   = IDX_WIDTH'(i);
            end
        end
        for (int i = 0; i < N_ROUTINES; i++) begin
            if (current == IDX_WIDTH'(i)) done_sel = routine_done[i];
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_next = first_found ? ST_CLEAR : ST_DONE;
            ST_CLEAR:         state_next = ST_LAUNCH;
            ST_LAUNCH:        state_next = ST_WAIT;
            ST_WAIT:          if (done_sel || timeout_hit) state_next = ST_NEXT;
            ST_NEXT:          state_next = next_found ? ST_CLEAR : ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state   <= ST_IDLE;
            mask    <= '0;
            current <= '0;
        end else begin
            state <= state_next;
            if (start_accept) begin
                mask    <= enable;
                current <= first_idx;
            end else if (state == ST_NEXT && next_found) begin
                current <= next_idx;
            end
        end
    end

    always_comb begin
        routine_start = '0;
        routine_nrst  = '1;
        for (int i = 0; i < N_ROUTINES; i++) begin
            if (current == IDX_WIDTH'(i)) begin
                routine_nrst[i]  = (state != ST_CLEAR);
                routine_start[i] = (state == ST_LAUNCH);
            end
        end
    end

    assign busy  = !(state == ST_IDLE || state == ST_DONE);
    assign done  = (state == ST_DONE);
    assign grant = (state == ST_CLEAR) || (state == ST_LAUNCH) || (state == ST_WAIT);

`ifdef ROUTINE_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle of the current routine.
    assign timeout_hit = (state == ST_WAIT) && !done_sel &&
                         ((32'(wait_cnt) + 32'd1) >= 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            wait_cnt    <= '0;
            timeout_err <= '0;
        end else begin
            if (state == ST_LAUNCH)    wait_cnt <= '0;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + 16'd1;
            if (start_accept) begin
                timeout_err <= '0;
            end else if (timeout_hit) begin
                for (int i = 0; i < N_ROUTINES; i++) begin
                    if (current == IDX_WIDTH'(i)) timeout_err[i] <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_err        = '0;
`endif

    routine_bus_mux #(
        .WORD_WIDTH (WORD_WIDTH),
        .N_ROUTINES (N_ROUTINES),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_bus_mux (
        .grant            (grant),
        .sel              (current),
        .routine_address  (routine_address),
        .routine_wr_en    (routine_wr_en),
        .routine_data_out (routine_data_out),
        .mem_address      (mem_address),
        .mem_wr_en        (mem_wr_en),
        .mem_data_out     (mem_data_out)
    );

endmodule

// File: tb/tb_routine_scheduler.sv
// Directed bench for routine_scheduler; routine slots are simple delay-to-done responders.
module tb_routine_scheduler;

    logic        clock;
    logic        nrst;
    logic        start;
    logic [3:0]  enable;
    logic [3:0]  routine_done;
    logic [63:0] routine_address;
    logic [3:0]  routine_wr_en;
    logic [63:0] routine_data_out;
    logic [3:0]  routine_start;
    logic [3:0]  routine_nrst;
    logic [15:0] mem_address;
    logic        mem_wr_en;
    logic [15:0] mem_data_out;
    logic        busy;
    logic        done;
    logic [2:0]  current;
    logic [3:0]  timeout_err;

    int vectors;
    int miscompares;

    // Responder state per slot: delay 0 means the slot never finishes.
    int delay [4];
    int cnt [4];
    bit running [4];
    int launches [$];
    bit saw_bad_start, saw_bad_bus, saw_any_start, saw_any_clear;

    routine_scheduler #(
        .WORD_WIDTH     (16),
        .N_ROUTINES     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock            (clock),
        .nrst             (nrst),
        .start            (start),
        .enable           (enable),
        .routine_done     (routine_done),
        .routine_address  (routine_address),
        .routine_wr_en    (routine_wr_en),
        .routine_data_out (routine_data_out),
        .routine_start    (routine_start),
        .routine_nrst     (routine_nrst),
        .mem_address      (mem_address),
        .mem_wr_en        (mem_wr_en),
        .mem_data_out     (mem_data_out),
        .busy             (busy),
        .done             (done),
        .current          (current),
        .timeout_err      (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            cnt[i]     = 0;
            running[i] = 1'b0;
        end
        routine_done  = 4'b0000;
        routine_wr_en = 4'b1010;
    endtask

    // Advance to the next falling edge, record activity, and update the responders.
    task automatic step();
        @(negedge clock);
        if (routine_start[1] || routine_start[3]) saw_bad_start = 1'b1;
        if (mem_address == 16'hA5A5 || mem_data_out == 16'h5A5A) saw_bad_bus = 1'b1;
        if (routine_start != 4'b0000) saw_any_start = 1'b1;
        if (routine_nrst != 4'b1111) saw_any_clear = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (routine_start[i]) launches.push_back(i);
            if (!routine_nrst[i]) begin
                routine_done[i] = 1'b0;
                running[i]      = 1'b0;
                cnt[i]          = 0;
            end else if (routine_start[i]) begin
                running[i] = 1'b1;
                cnt[i]     = delay[i];
            end else if (running[i] && delay[i] != 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    routine_done[i] = 1'b1;
                    running[i]      = 1'b0;
                end
            end
        end
        routine_wr_en = {1'b1, running[2], 1'b1, running[0]};
    endtask

    task automatic run_start(input logic [3:0] en);
        enable = en;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: done=%b after %0d cycles, expected 1", name, done, k);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, done, current, routine_start, routine_nrst, timeout_err} !== {1'b0, 1'b0, 3'd0, 4'b0000, 4'b1111, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy=%b done=%b current=%0d start=%b nrst=%b terr=%b", busy, done, current, routine_start, routine_nrst, timeout_err);
        end
        vectors++;
        if ({mem_address, mem_wr_en, mem_data_out} !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_bus: addr=%h we=%b data=%h, expected all zero", mem_address, mem_wr_en, mem_data_out);
        end
    endtask

    task automatic test_sequence();
        delay = '{5, 5, 5, 5};
        launches.delete();
        saw_bad_start = 1'b0;
        saw_bad_bus   = 1'b0;
        run_start(4'b0101);
        vectors++;
        if ({routine_nrst, routine_start, current, busy, done} !== {4'b1110, 4'b0000, 3'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL seq_clear: nrst=%b start=%b current=%0d busy=%b done=%b", routine_nrst, routine_start, current, busy, done);
        end
        step();
        vectors++;
        if ({routine_start, routine_nrst} !== {4'b0001, 4'b1111}) begin
            miscompares++;
            $display("FAIL seq_launch: start=%b nrst=%b, expected 0001/1111", routine_start, routine_nrst);
        end
        step();
        vectors++;
        if ({mem_address, mem_wr_en, mem_data_out} !== {16'h0002, 1'b1, 16'h0001}) begin
            miscompares++;
            $display("FAIL seq_bus_write: addr=%h we=%b data=%h, expected 0002/1/0001", mem_address, mem_wr_en, mem_data_out);
        end
        repeat (13) step();
        vectors++;
        if ({done, busy, current} !== {1'b0, 1'b1, 3'd2}) begin
            miscompares++;
            $display("FAIL seq_next: done=%b busy=%b current=%0d, expected 0/1/2", done, busy, current);
        end
        vectors++;
        if ({mem_address, mem_wr_en, mem_data_out} !== 33'd0) begin
            miscompares++;
            $display("FAIL seq_bus_idle: addr=%h we=%b data=%h in NEXT", mem_address, mem_wr_en, mem_data_out);
        end
        step();
        vectors++;
        if ({done, busy, current} !== {1'b1, 1'b0, 3'd2}) begin
            miscompares++;
            $display("FAIL seq_done_cycle: done=%b busy=%b current=%0d, expected 1/0/2", done, busy, current);
        end
        vectors++;
        if (launches.size() != 2 || launches[0] != 0 || launches[1] != 2) begin
            miscompares++;
            $display("FAIL seq_order: %0d launches, first=%0d, expected slots 0 then 2", launches.size(), (launches.size() > 0) ? launches[0] : -1);
        end
        vectors++;
        if ({saw_bad_start, saw_bad_bus} !== 2'b00) begin
            miscompares++;
            $display("FAIL seq_isolation: bad_start=%b bad_bus=%b, expected 0/0", saw_bad_start, saw_bad_bus);
        end
    endtask

    task automatic test_empty();
        saw_any_start = 1'b0;
        saw_any_clear = 1'b0;
        run_start(4'b0000);
        vectors++;
        if ({done, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL empty_done: done=%b busy=%b, expected 1/0", done, busy);
        end
        repeat (3) step();
        vectors++;
        if ({saw_any_start, saw_any_clear} !== 2'b00) begin
            miscompares++;
            $display("FAIL empty_quiet: start_seen=%b clear_seen=%b, expected 0/0", saw_any_start, saw_any_clear);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        delay = '{2, 0, 5, 5};
        launches.delete();
        run_start(4'b0011);
        while (!(launches.size() > 1) && k < 40) begin
            step();
            k++;
        end
        step();
        step();
        vectors++;
        if ({current, mem_address, mem_wr_en} !== {3'd1, 16'hA5A5, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_pre_wait: current=%0d addr=%h we=%b, expected 1/a5a5/1", current, mem_address, mem_wr_en);
        end
        #2 nrst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, current, routine_start, routine_nrst, timeout_err} !== {1'b0, 1'b0, 3'd0, 4'b0000, 4'b1111, 4'b0000}) begin
            miscompares++;
            $display("FAIL rst_async_ctrl: busy=%b done=%b current=%0d start=%b nrst=%b terr=%b", busy, done, current, routine_start, routine_nrst, timeout_err);
        end
        vectors++;
        if ({mem_address, mem_wr_en, mem_data_out} !== 33'd0) begin
            miscompares++;
            $display("FAIL rst_async_bus: addr=%h we=%b data=%h, expected all zero", mem_address, mem_wr_en, mem_data_out);
        end
        step();
        clear_model();
        nrst = 1'b1;
        step();
        run_start(4'b0001);
        vectors++;
        if ({current, routine_nrst} !== {3'd0, 4'b1110}) begin
            miscompares++;
            $display("FAIL rst_restart: current=%0d nrst=%b, expected 0/1110", current, routine_nrst);
        end
        wait_done(40, "rst_restart_done");
    endtask

    task automatic test_start_ignored();
        delay = '{6, 3, 5, 5};
        launches.delete();
        run_start(4'b0011);
        step();
        step();
        enable = 4'b1100;
        start  = 1'b1;
        step();
        start  = 1'b0;
        vectors++;
        if ({current, routine_nrst, busy} !== {3'd0, 4'b1111, 1'b1}) begin
            miscompares++;
            $display("FAIL busy_start_ignored: current=%0d nrst=%b busy=%b, expected 0/1111/1", current, routine_nrst, busy);
        end
        wait_done(60, "busy_start_done");
        vectors++;
        if (launches.size() != 2 || launches[0] != 0 || launches[1] != 1) begin
            miscompares++;
            $display("FAIL busy_start_order: %0d launches, expected slots 0 then 1", launches.size());
        end
        run_start(4'b0011);
        vectors++;
        if ({routine_nrst, busy, done} !== {4'b1110, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rerun_clear: nrst=%b busy=%b done=%b, expected 1110/1/0", routine_nrst, busy, done);
        end
        wait_done(60, "rerun_done");
    endtask

`ifdef ROUTINE_TIMEOUT_EN
    task automatic test_timeout();
        delay = '{0, 2, 5, 5};
        run_start(4'b0011);
        repeat (9) step();
        vectors++;
        if ({timeout_err, current, busy} !== {4'b0000, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL tmo_last_wait: terr=%b current=%0d busy=%b, expected 0000/0/1", timeout_err, current, busy);
        end
        step();
        vectors++;
        if (timeout_err !== 4'b0001) begin
            miscompares++;
            $display("FAIL tmo_flag: terr=%b, expected 0001", timeout_err);
        end
        step();
        vectors++;
        if ({current, routine_nrst} !== {3'd1, 4'b1101}) begin
            miscompares++;
            $display("FAIL tmo_continue: current=%0d nrst=%b, expected 1/1101", current, routine_nrst);
        end
        wait_done(40, "tmo_done");
        delay = '{1, 2, 5, 5};
        run_start(4'b0011);
        vectors++;
        if (timeout_err !== 4'b0000) begin
            miscompares++;
            $display("FAIL tmo_clear_on_start: terr=%b, expected 0000", timeout_err);
        end
        wait_done(40, "tmo_rerun_done");
    endtask
`else
    task automatic test_timeout();
        delay = '{20, 5, 5, 5};
        run_start(4'b0001);
        wait_done(60, "no_tmo_done");
        vectors++;
        if (timeout_err !== 4'b0000) begin
            miscompares++;
            $display("FAIL no_tmo_flag: terr=%b, expected 0000", timeout_err);
        end
    endtask
`endif

    initial begin
        vectors          = 0;
        miscompares      = 0;
        nrst             = 1'b0;
        start            = 1'b0;
        enable           = 4'b0000;
        routine_address  = {16'h0040, 16'h0030, 16'hA5A5, 16'h0002};
        routine_data_out = {16'h0044, 16'h0033, 16'h5A5A, 16'h0001};
        delay            = '{5, 5, 5, 5};
        clear_model();
        step();
        step();
        test_reset();
        nrst = 1'b1;
        step();
        test_sequence();
        test_empty();
        test_reset_mid();
        test_start_ignored();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
